// File: rtl/crc_feeder_pkg.sv
// Shared definitions for the CRC APB feeder: FSM states, CRC register map,
// CTRL field encodings and the result masking helper.
package crc_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_CTRL,
    WR_INIT,
    WR_XORV,
    WR_DATA,
    RD_STAT,
    RD_DATA,
    RESP
  } feeder_state_t;

  localparam logic [31:0] OFF_CTRL = 32'h0000_0000;
  localparam logic [31:0] OFF_INIT = 32'h0000_0004;
  localparam logic [31:0] OFF_XORV = 32'h0000_0008;
  localparam logic [31:0] OFF_DATA = 32'h0000_000C;
  localparam logic [31:0] OFF_STAT = 32'h0000_0010;

  localparam logic [1:0] MODE_CRC8       = 2'd0;
  localparam logic [1:0] MODE_CRC16_1021 = 2'd1;
  localparam logic [1:0] MODE_CRC16_8005 = 2'd2;
  localparam logic [1:0] MODE_CRC32      = 2'd3;

  localparam logic [1:0] SIZE_8  = 2'd0;
  localparam logic [1:0] SIZE_16 = 2'd1;
  localparam logic [1:0] SIZE_24 = 2'd2;
  localparam logic [1:0] SIZE_32 = 2'd3;

  // The CRC leaves stale input bits above the active CRC width, so only the
  // bits belonging to the selected polynomial are kept.
  function automatic logic [31:0] mask_result(input logic [1:0] mode,
                                              input logic [31:0] data);
    logic [31:0] masked;
    case (mode)
      MODE_CRC8:       masked = {24'h0, data[7:0]};
      MODE_CRC16_1021,
      MODE_CRC16_8005: masked = {16'h0, data[15:0]};
      default:         masked = data;
    endcase
    return masked;
  endfunction

endpackage

// File: rtl/crc_apb_master.sv
// Single-transfer APB4 engine. While idle, a request is presented directly on
// the bus as the SETUP phase, so a request raised in the cycle after a
// completing ACCESS starts with no idle gap. The ACCESS phase uses registered
// copies of the request so the bus stays stable during pready waits.
module crc_apb_master (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] paddr,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  logic        access_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  // Enter ACCESS after a presented SETUP, leave it when the slave is ready.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      access_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (!access_q) begin
      if (req) begin
        access_q <= 1'b1;
        we_q     <= we;
        addr_q   <= addr;
        wdata_q  <= wdata;
      end
    end else if (pready) begin
      access_q <= 1'b0;
    end
  end

  assign psel    = access_q | req;
  assign penable = access_q;
  assign paddr   = access_q ? addr_q  : (req ? addr  : 32'h0);
  assign pwrite  = access_q ? we_q    : (req ? we    : 1'b0);
  assign pwdata  = access_q ? wdata_q : (req ? wdata : 32'h0);
  assign pstrb   = 4'hF;

  assign done  = access_q & pready;
  assign err   = access_q & pready & pslverr;
  assign rdata = prdata;

endmodule

// File: rtl/crc_apb_feeder.sv
// APB4 master feeding the CRC peripheral from a valid/ready job stream.
// Per job it writes CTRL/INIT/XORV (each skipped when equal to the cached
// value), writes DATA, polls STAT until done, reads DATA and returns the
// mode-masked result on the response port.
// Optional build macro CRC_FEEDER_TIMEOUT_EN bounds STAT polling to POLL_MAX
// reads and reports a timeout as an error response.
module crc_apb_feeder
  import crc_feeder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned POLL_MAX  = 16
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        job_valid_i,
  output logic        job_ready_o,
  input  logic [6:0]  job_ctrl_i,
  input  logic [31:0] job_init_i,
  input  logic [31:0] job_xorv_i,
  input  logic [31:0] job_data_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [31:0] res_data_o,
  output logic        res_err_o,
  output logic [31:0] paddr_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] pwdata_o,
  output logic [3:0]  pstrb_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i
);

  feeder_state_t state_q, state_d, eff_state;

  logic [6:0]  job_ctrl_q;
  logic [31:0] job_init_q;
  logic [31:0] job_xorv_q;
  logic [31:0] job_data_q;
  logic [6:0]  wr_ctrl;

  logic        ctrl_ok_q, init_ok_q, xorv_ok_q;
  logic [6:0]  cache_ctrl_q;
  logic [31:0] cache_init_q;
  logic [31:0] cache_xorv_q;

  logic [31:0] res_data_q;
  logic        res_err_q;

  logic        mst_req, mst_we, mst_done, mst_err;
  logic [31:0] mst_off, mst_wdata, mst_rdata;
  logic        poll_timeout;

  // The enable bit is always written as 1, and the cache holds the value
  // actually written, so the comparison uses the forced value too.
  assign wr_ctrl = job_ctrl_q | 7'h01;

  // Skip configuration writes whose cached value already matches the job,
  // so a skipped register costs no cycles.
  always_comb begin
    eff_state = state_q;
    if (eff_state == WR_CTRL && ctrl_ok_q && cache_ctrl_q == wr_ctrl)
      eff_state = WR_INIT;
    if (eff_state == WR_INIT && init_ok_q && cache_init_q == job_init_q)
      eff_state = WR_XORV;
    if (eff_state == WR_XORV && xorv_ok_q && cache_xorv_q == job_xorv_q)
      eff_state = WR_DATA;
  end

  // Translate the effective state into the APB transfer it performs.
  always_comb begin
    mst_req   = 1'b0;
    mst_we    = 1'b0;
    mst_off   = OFF_CTRL;
    mst_wdata = 32'h0;
    case (eff_state)
      WR_CTRL: begin
        mst_req   = 1'b1;
        mst_we    = 1'b1;
        mst_off   = OFF_CTRL;
        mst_wdata = {25'h0, wr_ctrl};
      end
      WR_INIT: begin
        mst_req   = 1'b1;
        mst_we    = 1'b1;
        mst_off   = OFF_INIT;
        mst_wdata = job_init_q;
      end
      WR_XORV: begin
        mst_req   = 1'b1;
        mst_we    = 1'b1;
        mst_off   = OFF_XORV;
        mst_wdata = job_xorv_q;
      end
      WR_DATA: begin
        mst_req   = 1'b1;
        mst_we    = 1'b1;
        mst_off   = OFF_DATA;
        mst_wdata = job_data_q;
      end
      RD_STAT: begin
        mst_req = 1'b1;
        mst_off = OFF_STAT;
      end
      RD_DATA: begin
        mst_req = 1'b1;
        mst_off = OFF_DATA;
      end
      default: ;
    endcase
  end

  crc_apb_master u_master (
    .pclk    (pclk),
    .presetn (presetn),
    .req     (mst_req),
    .we      (mst_we),
    .addr    (BASE_ADDR + mst_off),
    .wdata   (mst_wdata),
    .done    (mst_done),
    .rdata   (mst_rdata),
    .err     (mst_err),
    .paddr   (paddr_o),
    .psel    (psel_o),
    .penable (penable_o),
    .pwrite  (pwrite_o),
    .pwdata  (pwdata_o),
    .pstrb   (pstrb_o),
    .prdata  (prdata_i),
    .pready  (pready_i),
    .pslverr (pslverr_i)
  );

`ifdef CRC_FEEDER_TIMEOUT_EN
  localparam int POLL_W = $clog2(POLL_MAX + 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MAX - 1);

  logic [POLL_W-1:0] poll_cnt_q;

  assign poll_timeout = (eff_state == RD_STAT) && mst_done && !mst_err &&
                        !mst_rdata[0] && (poll_cnt_q == POLL_LAST);

  // Count STAT reads that came back not-done since the DATA write.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)
      poll_cnt_q <= '0;
    else if (eff_state == WR_DATA && mst_done)
      poll_cnt_q <= '0;
    else if (eff_state == RD_STAT && mst_done && !mst_err && !mst_rdata[0])
      poll_cnt_q <= poll_cnt_q + 1'b1;
  end
`else
  assign poll_timeout = 1'b0;
`endif

  // Next-state sequencing; any failed transfer aborts straight to RESP.
  always_comb begin
    state_d = eff_state;
    case (eff_state)
      IDLE:    if (job_valid_i) state_d = WR_CTRL;
      WR_CTRL: if (mst_done) state_d = mst_err ? RESP : WR_INIT;
      WR_INIT: if (mst_done) state_d = mst_err ? RESP : WR_XORV;
      WR_XORV: if (mst_done) state_d = mst_err ? RESP : WR_DATA;
      WR_DATA: if (mst_done) state_d = mst_err ? RESP : RD_STAT;
      RD_STAT: begin
        if (mst_done) begin
          if (mst_err || poll_timeout) state_d = RESP;
          else if (mst_rdata[0])       state_d = RD_DATA;
          else                         state_d = RD_STAT;
        end
      end
      RD_DATA: if (mst_done) state_d = RESP;
      RESP:    if (res_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Capture the job on acceptance; it is held for the whole sequence.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      job_ctrl_q <= '0;
      job_init_q <= '0;
      job_xorv_q <= '0;
      job_data_q <= '0;
    end else if (state_q == IDLE && job_valid_i) begin
      job_ctrl_q <= job_ctrl_i;
      job_init_q <= job_init_i;
      job_xorv_q <= job_xorv_i;
      job_data_q <= job_data_i;
    end
  end

  // Track written config values and build the response on completion.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ctrl_ok_q    <= 1'b0;
      init_ok_q    <= 1'b0;
      xorv_ok_q    <= 1'b0;
      cache_ctrl_q <= '0;
      cache_init_q <= '0;
      cache_xorv_q <= '0;
      res_data_q   <= '0;
      res_err_q    <= 1'b0;
    end else if (mst_done) begin
      if (mst_err || poll_timeout) begin
        ctrl_ok_q  <= 1'b0;
        init_ok_q  <= 1'b0;
        xorv_ok_q  <= 1'b0;
        res_data_q <= '0;
        res_err_q  <= 1'b1;
      end else begin
        case (eff_state)
          WR_CTRL: begin
            cache_ctrl_q <= wr_ctrl;
            ctrl_ok_q    <= 1'b1;
          end
          WR_INIT: begin
            cache_init_q <= job_init_q;
            init_ok_q    <= 1'b1;
          end
          WR_XORV: begin
            cache_xorv_q <= job_xorv_q;
            xorv_ok_q    <= 1'b1;
          end
          RD_DATA: begin
            res_data_q <= mask_result(job_ctrl_q[4:3], mst_rdata);
            res_err_q  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign job_ready_o = (state_q == IDLE);
  assign res_valid_o = (state_q == RESP);
  assign res_data_o  = res_data_q;
  assign res_err_o   = res_err_q;

endmodule

// File: tb/tb_crc_apb_feeder.sv
// Directed self-checking bench for crc_apb_feeder with a behavioural APB
// slave standing in for the CRC peripheral.
module tb_crc_apb_feeder;

  localparam logic [31:0] BASE = 32'h4000_1000;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        job_valid_i = 1'b0;
  logic        job_ready_o;
  logic [6:0]  job_ctrl_i = '0;
  logic [31:0] job_init_i = '0;
  logic [31:0] job_xorv_i = '0;
  logic [31:0] job_data_i = '0;
  logic        res_valid_o;
  logic        res_ready_i = 1'b0;
  logic [31:0] res_data_o;
  logic        res_err_o;
  logic [31:0] paddr_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic [31:0] prdata_i = '0;
  logic        pready_i = 1'b0;
  logic        pslverr_i = 1'b0;

  int checks = 0;
  int failures = 0;

  // slave configuration
  int          wait_states = 0;
  int          stat_zero_left = 0;
  bit          stat_always_zero = 0;
  logic [31:0] data_ret = '0;
  bit          err_arm = 0;
  logic [31:0] err_off = '0;

  // slave log
  int          wr_ctrl_cnt = 0, wr_init_cnt = 0, wr_xorv_cnt = 0, wr_data_cnt = 0;
  int          stat_reads = 0, stab_err = 0;
  logic [31:0] last_ctrl_w = '0, last_data_w = '0;

  logic [31:0] s_addr = '0, s_wdata = '0, s_off;
  logic        s_we = 1'b0;
  int          s_wait = 0;

  crc_apb_feeder #(.BASE_ADDR(BASE), .POLL_MAX(4)) dut (
    .pclk(pclk), .presetn(presetn),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_ctrl_i(job_ctrl_i), .job_init_i(job_init_i),
    .job_xorv_i(job_xorv_i), .job_data_i(job_data_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o), .res_err_o(res_err_o),
    .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  always #5 pclk = ~pclk;

  // APB slave: responds on the falling edge for the next rising edge.
  always @(negedge pclk) begin
    pready_i  = 1'b0;
    pslverr_i = 1'b0;
    prdata_i  = '0;
    if (presetn && psel_o && !penable_o) begin
      s_addr  = paddr_o;
      s_we    = pwrite_o;
      s_wdata = pwdata_o;
      s_wait  = 0;
    end else if (presetn && psel_o && penable_o) begin
      if (paddr_o !== s_addr || pwrite_o !== s_we || pwdata_o !== s_wdata)
        stab_err++;
      if (s_wait < wait_states) begin
        s_wait++;
      end else begin
        pready_i = 1'b1;
        s_off = s_addr - BASE;
        if (err_arm && s_off == err_off) begin
          pslverr_i = 1'b1;
          err_arm = 0;
        end
        if (s_we) begin
          case (s_off)
            32'h00: begin wr_ctrl_cnt++; last_ctrl_w = s_wdata; end
            32'h04: wr_init_cnt++;
            32'h08: wr_xorv_cnt++;
            32'h0C: begin wr_data_cnt++; last_data_w = s_wdata; end
            default: ;
          endcase
        end else if (s_off == 32'h10) begin
          stat_reads++;
          if (stat_always_zero) prdata_i = 32'h0;
          else if (stat_zero_left > 0) begin
            prdata_i = 32'h0;
            stat_zero_left--;
          end else prdata_i = 32'h1;
        end else if (s_off == 32'h0C) begin
          prdata_i = data_ret;
        end
      end
    end
  end

  task automatic clear_log();
    wr_ctrl_cnt = 0; wr_init_cnt = 0; wr_xorv_cnt = 0; wr_data_cnt = 0;
    stat_reads = 0; stab_err = 0;
  endtask

  task automatic send_job(input logic [6:0] c, input logic [31:0] i,
                          input logic [31:0] x, input logic [31:0] d,
                          output bit ok);
    ok = 0;
    @(negedge pclk);
    job_valid_i = 1'b1;
    job_ctrl_i = c; job_init_i = i; job_xorv_i = x; job_data_i = d;
    for (int n = 0; n < 100; n++) begin
      if (job_ready_o) begin ok = 1; break; end
      @(negedge pclk);
    end
    @(negedge pclk);
    job_valid_i = 1'b0;
  endtask

  task automatic await_result(output bit ok);
    ok = 0;
    for (int n = 0; n < 400; n++) begin
      if (res_valid_o) begin ok = 1; break; end
      @(negedge pclk);
    end
  endtask

  task automatic release_result();
    res_ready_i = 1'b1;
    @(negedge pclk);
    res_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    repeat (2) @(negedge pclk);
    checks++; if (job_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL reset_job_ready actual=%b expected=1", job_ready_o); end
    checks++; if (res_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_res_valid actual=%b expected=0", res_valid_o); end
    checks++; if (res_data_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_res_data actual=%h expected=0", res_data_o); end
    checks++; if (res_err_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_res_err actual=%b expected=0", res_err_o); end
    checks++; if ({psel_o, penable_o, pwrite_o} !== 3'b000) begin failures++; $display("[TB] FAIL reset_apb_ctl actual=%b expected=000", {psel_o, penable_o, pwrite_o}); end
    checks++; if (paddr_o !== 32'h0 || pwdata_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_apb_bus actual=%h/%h expected=0/0", paddr_o, pwdata_o); end
    presetn = 1'b1;
    @(negedge pclk);
    checks++; if (psel_o !== 1'b0) begin failures++; $display("[TB] FAIL idle_psel actual=%b expected=0", psel_o); end
  endtask

  task automatic test_crc8();
    bit ok, got;
    clear_log(); wait_states = 0; stat_zero_left = 1; data_ret = 32'hDEAD_BE07;
    send_job(7'h01, 32'h0, 32'h0, 32'h01, ok);
    await_result(got);
    checks++; if (!(ok && got)) begin failures++; $display("[TB] FAIL crc8_handshake actual=%b%b expected=11", ok, got); end
    checks++; if (res_data_o !== 32'h07) begin failures++; $display("[TB] FAIL crc8_data actual=%h expected=00000007", res_data_o); end
    checks++; if (res_data_o[31:8] !== 24'h0) begin failures++; $display("[TB] FAIL crc8_upper_masked actual=%h expected=0", res_data_o[31:8]); end
    checks++; if (res_err_o !== 1'b0) begin failures++; $display("[TB] FAIL crc8_err actual=%b expected=0", res_err_o); end
    checks++; if ({wr_ctrl_cnt, wr_init_cnt, wr_xorv_cnt, wr_data_cnt} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin failures++; $display("[TB] FAIL crc8_writes actual=%0d/%0d/%0d/%0d expected=1/1/1/1", wr_ctrl_cnt, wr_init_cnt, wr_xorv_cnt, wr_data_cnt); end
    checks++; if (last_ctrl_w !== 32'h01 || last_data_w !== 32'h01) begin failures++; $display("[TB] FAIL crc8_wdata actual=%h/%h expected=1/1", last_ctrl_w, last_data_w); end
    checks++; if (stat_reads !== 2) begin failures++; $display("[TB] FAIL crc8_stat_reads actual=%0d expected=2", stat_reads); end
    release_result();
    checks++; if (res_valid_o !== 1'b0 || job_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL crc8_release actual=%b%b expected=01", res_valid_o, job_ready_o); end
  endtask

  task automatic test_config_skip();
    bit ok, got;
    clear_log(); stat_zero_left = 0; data_ret = 32'h3300_1021;
    send_job(7'h09, 32'h0, 32'h0, 32'h01, ok);
    await_result(got);
    checks++; if (!(ok && got)) begin failures++; $display("[TB] FAIL skip_handshake actual=%b%b expected=11", ok, got); end
    checks++; if (res_data_o !== 32'h1021) begin failures++; $display("[TB] FAIL skip_data actual=%h expected=00001021", res_data_o); end
    checks++; if (wr_ctrl_cnt + wr_init_cnt + wr_xorv_cnt + wr_data_cnt !== 2 || wr_ctrl_cnt !== 1) begin failures++; $display("[TB] FAIL skip_writes actual=%0d/%0d/%0d/%0d expected=1/0/0/1", wr_ctrl_cnt, wr_init_cnt, wr_xorv_cnt, wr_data_cnt); end
    checks++; if (last_ctrl_w !== 32'h09) begin failures++; $display("[TB] FAIL skip_ctrl_wdata actual=%h expected=09", last_ctrl_w); end
    release_result();
  endtask

  task automatic test_crc32();
    bit ok, got;
    clear_log(); stat_zero_left = 0; data_ret = 32'h04C1_1DB7;
    send_job(7'h18, 32'h0, 32'h0, 32'h01, ok);
    await_result(got);
    checks++; if (!(ok && got)) begin failures++; $display("[TB] FAIL crc32_handshake actual=%b%b expected=11", ok, got); end
    checks++; if (res_data_o !== 32'h04C1_1DB7) begin failures++; $display("[TB] FAIL crc32_data actual=%h expected=04c11db7", res_data_o); end
    checks++; if (last_ctrl_w !== 32'h19) begin failures++; $display("[TB] FAIL crc32_en_forced actual=%h expected=19", last_ctrl_w); end
    checks++; if (wr_ctrl_cnt + wr_init_cnt + wr_xorv_cnt + wr_data_cnt !== 2) begin failures++; $display("[TB] FAIL crc32_writes actual=%0d expected=2", wr_ctrl_cnt + wr_init_cnt + wr_xorv_cnt + wr_data_cnt); end
    release_result();
  endtask

  task automatic test_wait_states();
    bit ok, got;
    clear_log(); wait_states = 3; stat_zero_left = 5; data_ret = 32'hCAFE_F00D;
    send_job(7'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00A5, ok);
    await_result(got);
    checks++; if (!(ok && got)) begin failures++; $display("[TB] FAIL wait_handshake actual=%b%b expected=11", ok, got); end
    checks++; if ({wr_ctrl_cnt, wr_init_cnt, wr_xorv_cnt, wr_data_cnt} !== {32'd0, 32'd1, 32'd1, 32'd1}) begin failures++; $display("[TB] FAIL wait_writes actual=%0d/%0d/%0d/%0d expected=0/1/1/1", wr_ctrl_cnt, wr_init_cnt, wr_xorv_cnt, wr_data_cnt); end
    checks++; if (stat_reads !== 6) begin failures++; $display("[TB] FAIL wait_stat_reads actual=%0d expected=6", stat_reads); end
    checks++; if (stab_err !== 0) begin failures++; $display("[TB] FAIL wait_bus_stable actual=%0d expected=0", stab_err); end
    checks++; if (last_data_w !== 32'h0000_00A5) begin failures++; $display("[TB] FAIL wait_data_wdata actual=%h expected=000000a5", last_data_w); end
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (res_valid_o !== 1'b1 || res_data_o !== 32'hCAFE_F00D || res_err_o !== 1'b0) begin
        failures++;
        $display("[TB] FAIL wait_hold_%0d actual=%b/%h/%b expected=1/cafef00d/0", n, res_valid_o, res_data_o, res_err_o);
      end
      @(negedge pclk);
    end
    release_result();
    wait_states = 0;
  endtask

  task automatic test_slverr();
    bit ok, got;
    clear_log(); stat_zero_left = 0; err_arm = 1; err_off = 32'h04; data_ret = 32'h0000_ABCD;
    send_job(7'h19, 32'h1234_5678, 32'hFFFF_FFFF, 32'h01, ok);
    await_result(got);
    checks++; if (!(ok && got)) begin failures++; $display("[TB] FAIL err_handshake actual=%b%b expected=11", ok, got); end
    checks++; if (res_err_o !== 1'b1 || res_data_o !== 32'h0) begin failures++; $display("[TB] FAIL err_response actual=%b/%h expected=1/00000000", res_err_o, res_data_o); end
    checks++; if ({wr_ctrl_cnt, wr_init_cnt, wr_xorv_cnt, wr_data_cnt} !== {32'd0, 32'd1, 32'd0, 32'd0}) begin failures++; $display("[TB] FAIL err_abort actual=%0d/%0d/%0d/%0d expected=0/1/0/0", wr_ctrl_cnt, wr_init_cnt, wr_xorv_cnt, wr_data_cnt); end
    release_result();
    clear_log(); err_arm = 0;
    send_job(7'h19, 32'h1234_5678, 32'hFFFF_FFFF, 32'h01, ok);
    await_result(got);
    checks++; if (!(ok && got)) begin failures++; $display("[TB] FAIL reissue_handshake actual=%b%b expected=11", ok, got); end
    checks++; if ({wr_ctrl_cnt, wr_init_cnt, wr_xorv_cnt, wr_data_cnt} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin failures++; $display("[TB] FAIL reissue_writes actual=%0d/%0d/%0d/%0d expected=1/1/1/1", wr_ctrl_cnt, wr_init_cnt, wr_xorv_cnt, wr_data_cnt); end
    checks++; if (res_err_o !== 1'b0 || res_data_o !== 32'h0000_ABCD) begin failures++; $display("[TB] FAIL reissue_result actual=%b/%h expected=0/0000abcd", res_err_o, res_data_o); end
    release_result();
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    clear_log(); stat_always_zero = 1;
    send_job(7'h19, 32'h1234_5678, 32'hFFFF_FFFF, 32'h02, ok);
    seen = 0;
    for (int n = 0; n < 300; n++) begin
      if (stat_reads >= 2) begin seen = 1; break; end
      @(negedge pclk);
    end
    checks++; if (!(ok && seen && psel_o === 1'b1)) begin failures++; $display("[TB] FAIL midrst_polling actual=%b%b%b expected=111", ok, seen, psel_o); end
    #1 presetn = 1'b0;
    #1;
    checks++; if (psel_o !== 1'b0 || penable_o !== 1'b0) begin failures++; $display("[TB] FAIL midrst_psel actual=%b%b expected=00", psel_o, penable_o); end
    checks++; if (job_ready_o !== 1'b1 || res_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL midrst_ready actual=%b%b expected=10", job_ready_o, res_valid_o); end
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    stat_always_zero = 0;
    @(negedge pclk);
  endtask

`ifdef CRC_FEEDER_TIMEOUT_EN
  task automatic test_timeout();
    bit ok, got;
    clear_log(); stat_always_zero = 1;
    send_job(7'h01, 32'h0, 32'h0, 32'h01, ok);
    await_result(got);
    checks++; if (!(ok && got)) begin failures++; $display("[TB] FAIL timeout_handshake actual=%b%b expected=11", ok, got); end
    checks++; if (stat_reads !== 4) begin failures++; $display("[TB] FAIL timeout_stat_reads actual=%0d expected=4", stat_reads); end
    checks++; if (res_err_o !== 1'b1 || res_data_o !== 32'h0) begin failures++; $display("[TB] FAIL timeout_response actual=%b/%h expected=1/00000000", res_err_o, res_data_o); end
    release_result();
    stat_always_zero = 0;
  endtask
`endif

  initial begin
    $display("[TB] crc_apb_feeder directed bench start");
    test_reset();
    test_crc8();
    test_config_skip();
    test_crc32();
    test_wait_states();
    test_slverr();
    test_reset_mid();
`ifdef CRC_FEEDER_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crc_apb_feeder.md
Name: crc_apb_feeder

Overview:
- APB4 master that sits directly upstream of the APB4 CRC peripheral. It turns a valid/ready job stream of {ctrl, init, xorv, data} into the CRC's APB register sequence.
- Per job: write CTRL/INIT/XORV (skipped when unchanged), write DATA, poll STAT until done, read DATA. It then returns the mode-masked result on a valid/ready response port.
- Lets a stream engine or DMA use the CRC without CPU polling.

Parameters:
- BASE_ADDR, 32'h0000_0000, APB base address of the target CRC instance.
- POLL_MAX, 16, STAT reads before timeout; used only with the optional feature.

Ports:
- pclk  in  1  APB clock, the only clock.
- presetn  in  1  asynchronous active-low reset.
- job_valid_i  in  1  job offered.
- job_ready_o  out  1  job accepted when valid&&ready.
- job_ctrl_i  in  7  CRC CTRL: [0] en (forced 1 on write), [1] revin, [2] revout, [4:3] mode, [6:5] size.
- job_init_i  in  32  CRC INIT value.
- job_xorv_i  in  32  CRC XORV value.
- job_data_i  in  32  input data, 1–4 bytes, per size.
- res_valid_o  out  1  result available.
- res_ready_i  in  1  result consumed when valid&&ready.
- res_data_o  out  32  masked CRC result.
- res_err_o  out  1  job aborted (pslverr, or timeout when enabled).
- paddr_o  out  32  APB address.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- pwrite_o  out  1  APB direction.
- pwdata_o  out  32  APB write data.
- pstrb_o  out  4  always 4'hF.
- prdata_i  in  32  APB read data.
- pready_i  in  1  APB ready.
- pslverr_i  in  1  APB error.

Behaviour:
- Reset values: job_ready_o=1, res_valid_o=0, res_data_o=0, res_err_o=0, all APB outputs 0, FSM=IDLE, config cache invalid.
- Register offsets: CTRL 0x00, INIT 0x04, XORV 0x08, DATA 0x0C, STAT 0x10; paddr_o = BASE_ADDR + offset.
- FSM states: IDLE, WR_CTRL, WR_INIT, WR_XORV, WR_DATA, RD_STAT, RD_DATA, RESP.
- Each non-IDLE/non-RESP state performs one APB transfer:
  - SETUP cycle: psel=1, penable=0.
  - ACCESS cycles: psel=1, penable=1, held until pready_i.
  - paddr/pwrite/pwdata stay stable across both phases. Minimum 2 cycles per transfer. No idle cycle between back-to-back transfers: the next SETUP follows the completing ACCESS.
- IDLE: on job handshake, latch the job, drop job_ready_o, go to WR_CTRL.
- Config skip:
  - WR_CTRL is skipped if cache valid && ctrl matches the cached value; WR_INIT and WR_XORV likewise, each against its own cached field.
  - The cache updates on each completed write.
  - Skipping is evaluated combinationally, so a skipped state costs 0 cycles.
- WR_DATA writes job_data_i unmodified; the CRC aligns it.
- RD_STAT: read STAT; bit0=1 → RD_DATA, else repeat RD_STAT. Reading STAT clears it; the feeder never reads STAT anywhere else.
- RD_DATA: capture prdata_i masked by mode: mode 0 (CRC8) → [7:0]; mode 1/2 (CRC16) → [15:0]; mode 3 (CRC32) → [31:0]. Upper bits are zeroed, because the CRC leaves stale input bits there.
- RESP:
  - res_valid_o=1, res_err_o=0, outputs stable until res_ready_i.
  - On handshake: res_valid_o=0, job_ready_o=1 in the same cycle, → IDLE.
  - New job acceptance starts the following cycle; throughput is one job outstanding.
- pslverr_i=1 at any completing ACCESS:
  - Abort the remaining sequence, invalidate the cache, → RESP with res_err_o=1, res_data_o=0.
- Reset mid-operation: asynchronous return to reset values; an in-flight APB transfer is abandoned (psel drops immediately).

Optional Feature:
- Macro: CRC_FEEDER_TIMEOUT_EN.
- Defined:
  - A poll counter (width $clog2(POLL_MAX+1)) clears at WR_DATA completion and increments per completed STAT read with bit0=0.
  - When it reaches POLL_MAX: → RESP with res_err_o=1, res_data_o=0, cache invalidated.
- Undefined: no counter; polling is unbounded.

Decomposition:
- Package crc_feeder_pkg holds:
  - the FSM state enum;
  - register offset localparams;
  - mode encodings CRC8/CRC16_1021/CRC16_8005/CRC32 = 0..3;
  - size encodings 8/16/24/32 bits = 0..3;
  - a function mask_result(mode, data).
- One sub-module, crc_apb_master: a single-transfer APB engine. It takes req/we/addr/wdata, returns done/rdata/err, and owns SETUP/ACCESS sequencing and pready waits. The FSM stays in the top level.

Test Plan:
- CRC8 job: ctrl=7'b00_00_001, init=0, xorv=0, data=32'h01 → writes CTRL, INIT, XORV, DATA; polls STAT; res_data=32'h07, err=0.
- Repeat the same config with CRC16-1021 (ctrl mode=1, size=0, data=32'h01): only CTRL is rewritten, INIT/XORV skipped → res_data=32'h1021. Count APB writes = 2.
- CRC32 job: mode=3, init=0, data=32'h01 → res_data=32'h04C11DB7. Stale upper data bits are masked in the CRC8 case (check [31:8]=0).
- Slave model with pready low 3 cycles per transfer and STAT=0 for 5 reads:
  - every transfer's signals stay stable through the wait;
  - result correct after the 6th STAT read;
  - res_ready held low 4 cycles: outputs stable.
- pslverr on WR_INIT → res_err=1, data=0. The next identical job rewrites CTRL, INIT and XORV (cache invalidated).
- With CRC_FEEDER_TIMEOUT_EN and POLL_MAX=4, STAT always 0 → exactly 4 STAT reads, then res_err=1. presetn asserted mid-RD_STAT → psel_o=0 and job_ready_o=1 immediately.
